// File: rtl/corelet_pkg.sv
// corelet_pkg: shared state encoding, instruction codes and default geometry
// for the corelet tile sequencer.
package corelet_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      W_FILL = 3'd1,
      W_LOAD = 3'd2,
      X_FILL = 3'd3,
      EXEC   = 3'd4,
      DRAIN  = 3'd5,
      ACC    = 3'd6,
      DONE   = 3'd7
   } sched_state_e;

   // inst bus is {execute, kernel_load}
   localparam logic [1:0] INST_IDLE  = 2'b00;
   localparam logic [1:0] INST_KLOAD = 2'b01;
   localparam logic [1:0] INST_EXEC  = 2'b10;

   localparam int ROW_DEF     = 8;
   localparam int COL_DEF     = 8;
   localparam int KIJ_MAX_DEF = 9;

endpackage

// File: rtl/sched_addr_gen.sv
// sched_addr_gen: owns the kij, per-phase index (n) and accumulate-sweep (k/o)
// counters, and turns them plus the current state into xmem/pmem addresses.
module sched_addr_gen
   import corelet_pkg::*;
#(
   parameter int col     = COL_DEF,
   parameter int addr_w  = 11,
   parameter int kij_max = KIJ_MAX_DEF,
   parameter int cnt_w   = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  sched_state_e      state_i,
   input  logic [cnt_w-1:0]  numX_i,
   input  logic              nClr_i,
   input  logic              nInc_i,
   input  logic              kijClr_i,
   input  logic              kijInc_i,
   input  logic              accClr_i,
   input  logic              accStep_i,
   output logic [cnt_w:0]    nCnt_o,
   output logic              kijLast_o,
   output logic              kLast_o,
   output logic              accLast_o,
   output logic [addr_w-1:0] xmemAddr_o,
   output logic [addr_w-1:0] pmemAddr_o
);

   localparam int KW = $clog2(kij_max + 1);

   logic [KW-1:0]    kij_q;
   logic [KW-1:0]    k_q;
   logic [cnt_w:0]   n_q;
   logic [cnt_w-1:0] o_q;

   assign nCnt_o    = n_q;
   assign kijLast_o = (kij_q == KW'(kij_max - 1));
   assign kLast_o   = (k_q == KW'(kij_max - 1));
   assign accLast_o = kLast_o && (o_q == (numX_i - 1'b1));

   // kij and the per-phase index; a clear always wins over an increment
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         kij_q <= '0;
         n_q   <= '0;
      end else begin
         if (kijClr_i) begin
            kij_q <= '0;
         end else if (kijInc_i) begin
            kij_q <= kij_q + 1'b1;
         end
         if (nClr_i) begin
            n_q <= '0;
         end else if (nInc_i) begin
            n_q <= n_q + 1'b1;
         end
      end
   end

   // accumulate sweep walks every kij (inner) for each output row o (outer)
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         k_q <= '0;
         o_q <= '0;
      end else if (accClr_i) begin
         k_q <= '0;
         o_q <= '0;
      end else if (accStep_i) begin
         if (kLast_o) begin
            k_q <= '0;
            o_q <= o_q + 1'b1;
         end else begin
            k_q <= k_q + 1'b1;
         end
      end
   end

   // weights sit at the bottom of xmem, activations above all kij weight blocks
   always_comb begin
      xmemAddr_o = '0;
      pmemAddr_o = '0;
      case (state_i)
         W_FILL: xmemAddr_o = addr_w'(kij_q) * addr_w'(col) + addr_w'(n_q);
         X_FILL: xmemAddr_o = addr_w'(kij_max * col)
                            + addr_w'(kij_q) * addr_w'(numX_i) + addr_w'(n_q);
         DRAIN:  pmemAddr_o = addr_w'(kij_q) * addr_w'(numX_i) + addr_w'(n_q);
         ACC:    pmemAddr_o = addr_w'(k_q) * addr_w'(numX_i) + addr_w'(o_q);
         default: ;
      endcase
   end

endmodule

// File: rtl/corelet_sched.sv
// corelet_sched: per-tile sequencer. For each kij it fills L0 with weights,
// kernel-loads them, fills activations, executes, drains the OFIFO into pmem,
// and finally sweeps pmem through the SFUs with accumulate/ReLU.
// Optional build macro SCHED_PERF_CNT_EN adds perf_cycles/perf_stalls outputs.
module corelet_sched
   import corelet_pkg::*;
#(
   parameter int row     = ROW_DEF,
   parameter int col     = COL_DEF,
   parameter int addr_w  = 11,
   parameter int kij_max = KIJ_MAX_DEF,
   parameter int cnt_w   = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [cnt_w-1:0]  num_x,
   input  logic              mode,
   output logic              busy,
   output logic              done,
   output logic              xmem_cen,
   output logic [addr_w-1:0] xmem_addr,
   output logic              l0_wr,
   output logic              l0_rd,
   input  logic              l0_full,
   input  logic              l0_ready,
   output logic [1:0]        inst,
   output logic              ctrl,
   output logic              ofifo_rd,
   input  logic              ofifo_valid,
   output logic              pmem_cen,
   output logic              pmem_wen,
   output logic [addr_w-1:0] pmem_addr,
   output logic              acc,
   output logic              relu
`ifdef SCHED_PERF_CNT_EN
   ,
   output logic [31:0]       perf_cycles,
   output logic [31:0]       perf_stalls
`endif
);

   localparam int CW = cnt_w + 1;
   localparam logic [CW-1:0] COL_C       = CW'(col);
   localparam logic [CW-1:0] LOAD_LAST_C = CW'(col + row - 1);

   sched_state_e     state_q, state_d;
   logic [cnt_w-1:0] numX_q, numX_d;
   logic             ctrl_q, ctrl_d;
   logic             pend_q, pend_d;
   logic             acc_q, acc_d;
   logic             relu_q, relu_d;
   logic             tail_q, tail_d;
   logic [CW-1:0]    wrCnt_q, wrCnt_d;

   logic [CW-1:0]    fillLen;
   logic [CW-1:0]    numXExt;
   logic             readOk;
   logic             nClr, nInc, kijClr, kijInc, accClr, accStep;
   logic [CW-1:0]    nCnt;
   logic             kijLast, kLast, accLast;

   assign numXExt = {1'b0, numX_q};
   assign busy    = (state_q != IDLE) && (state_q != DONE);
   assign ctrl    = ctrl_q;
   assign acc     = acc_q;
   assign relu    = relu_q;

   sched_addr_gen #(
      .col     (col),
      .addr_w  (addr_w),
      .kij_max (kij_max),
      .cnt_w   (cnt_w)
   ) u_addr_gen (
      .clk        (clk),
      .reset      (reset),
      .state_i    (state_q),
      .numX_i     (numX_q),
      .nClr_i     (nClr),
      .nInc_i     (nInc),
      .kijClr_i   (kijClr),
      .kijInc_i   (kijInc),
      .accClr_i   (accClr),
      .accStep_i  (accStep),
      .nCnt_o     (nCnt),
      .kijLast_o  (kijLast),
      .kLast_o    (kLast),
      .accLast_o  (accLast),
      .xmemAddr_o (xmem_addr),
      .pmemAddr_o (pmem_addr)
   );

   // state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // latched configuration, pending-write flag, write count and SFU strobes
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         numX_q  <= '0;
         ctrl_q  <= 1'b0;
         pend_q  <= 1'b0;
         acc_q   <= 1'b0;
         relu_q  <= 1'b0;
         tail_q  <= 1'b0;
         wrCnt_q <= '0;
      end else begin
         numX_q  <= numX_d;
         ctrl_q  <= ctrl_d;
         pend_q  <= pend_d;
         acc_q   <= acc_d;
         relu_q  <= relu_d;
         tail_q  <= tail_d;
         wrCnt_q <= wrCnt_d;
      end
   end

   // next state and all per-cycle strobes; a read lands in L0 one cycle later
   // and is held there (pend_q) for as long as L0 reports full
   always_comb begin
      state_d  = state_q;
      numX_d   = numX_q;
      ctrl_d   = ctrl_q;
      pend_d   = 1'b0;
      acc_d    = 1'b0;
      relu_d   = 1'b0;
      tail_d   = tail_q;
      wrCnt_d  = wrCnt_q;
      fillLen  = COL_C;
      readOk   = 1'b0;
      nClr     = 1'b0;
      nInc     = 1'b0;
      kijClr   = 1'b0;
      kijInc   = 1'b0;
      accClr   = 1'b0;
      accStep  = 1'b0;
      xmem_cen = 1'b1;
      l0_wr    = 1'b0;
      l0_rd    = 1'b0;
      inst     = INST_IDLE;
      ofifo_rd = 1'b0;
      pmem_cen = 1'b1;
      pmem_wen = 1'b1;
      done     = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               numX_d  = num_x;
               ctrl_d  = mode;
               kijClr  = 1'b1;
               nClr    = 1'b1;
               wrCnt_d = '0;
               tail_d  = 1'b0;
               state_d = W_FILL;
            end
         end
         W_FILL, X_FILL: begin
            if (state_q == X_FILL) begin
               fillLen = numXExt;
            end
            l0_wr    = pend_q && !l0_full;
            readOk   = (nCnt < fillLen) && !l0_full;
            xmem_cen = !readOk;
            nInc     = readOk;
            pend_d   = readOk || (pend_q && l0_full);
            if (l0_wr) begin
               if (wrCnt_q == (fillLen - 1'b1)) begin
                  wrCnt_d = '0;
                  nClr    = 1'b1;
                  pend_d  = 1'b0;
                  state_d = (state_q == W_FILL) ? W_LOAD : EXEC;
               end else begin
                  wrCnt_d = wrCnt_q + 1'b1;
               end
            end
         end
         W_LOAD: begin
            l0_rd = (nCnt < COL_C);
            if (l0_rd) begin
               inst = INST_KLOAD;
            end
            if (nCnt == LOAD_LAST_C) begin
               nClr    = 1'b1;
               state_d = X_FILL;
            end else begin
               nInc = 1'b1;
            end
         end
         EXEC: begin
            if (l0_ready) begin
               l0_rd = 1'b1;
               inst  = INST_EXEC;
               if (nCnt == (numXExt - 1'b1)) begin
                  nClr    = 1'b1;
                  state_d = DRAIN;
               end else begin
                  nInc = 1'b1;
               end
            end
         end
         DRAIN: begin
            if (ofifo_valid) begin
               ofifo_rd = 1'b1;
               pmem_cen = 1'b0;
               pmem_wen = 1'b0;
               if (nCnt == (numXExt - 1'b1)) begin
                  nClr = 1'b1;
                  if (kijLast) begin
                     accClr  = 1'b1;
                     tail_d  = 1'b0;
                     state_d = ACC;
                  end else begin
                     kijInc  = 1'b1;
                     state_d = W_FILL;
                  end
               end else begin
                  nInc = 1'b1;
               end
            end
         end
         ACC: begin
            if (!tail_q) begin
               pmem_cen = 1'b0;
               accStep  = 1'b1;
               acc_d    = 1'b1;
               relu_d   = kLast;
               if (accLast) begin
                  tail_d = 1'b1;
               end
            end else begin
               tail_d  = 1'b0;
               state_d = DONE;
            end
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

`ifdef SCHED_PERF_CNT_EN
   logic [31:0] perfCycles_q;
   logic [31:0] perfStalls_q;
   logic        stall;

   assign stall = (((state_q == W_FILL) || (state_q == X_FILL)) && l0_full)
                || ((state_q == DRAIN) && !ofifo_valid);
   assign perf_cycles = perfCycles_q;
   assign perf_stalls = perfStalls_q;

   // busy-cycle and stall counters, restarted by each accepted start
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         perfCycles_q <= '0;
         perfStalls_q <= '0;
      end else if ((state_q == IDLE) && start) begin
         perfCycles_q <= '0;
         perfStalls_q <= '0;
      end else begin
         if (busy) begin
            perfCycles_q <= perfCycles_q + 32'd1;
         end
         if (stall) begin
            perfStalls_q <= perfStalls_q + 32'd1;
         end
      end
   end
`endif

endmodule
